// File: rtl/alu_8_bits_serial.sv
// Bit-serial ALU (AND/OR/XOR/ADD), one operand bit per cycle, LSB first, with valid/ready handshakes.
// Define ALU_SERIAL_ADD_EN to build the carry chain; without it OP=11 returns S=0, COUT=0.
module alu_8_bits_serial #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       OP,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             COUT
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   res_sh;
   logic [CNT_W-1:0]   cnt;
   logic               accept_c;
   logic               last_c;
   logic               bit_c;
   logic               carry_nxt_c;
   logic [WIDTH-1:0]   res_nxt_c;

   // Ready is gated by rst_n so it drops immediately while reset is held.
   assign in_ready = rst_n && (state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               accept_c  = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last_c    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef ALU_SERIAL_ADD_EN
   logic carry;

   always_ff @(posedge clk) begin
      if (!rst_n)                  carry <= 1'b0;
      else if (accept_c)           carry <= 1'b0;
      else if (state == ST_SHIFT)  carry <= carry_nxt_c;
   end
`endif

   // Single-bit slice of the selected operation.
   always_comb begin
      bit_c       = 1'b0;
      carry_nxt_c = 1'b0;
      case (op_q)
         2'b00: bit_c = a_sh[0] & b_sh[0];
         2'b01: bit_c = a_sh[0] | b_sh[0];
         2'b10: bit_c = a_sh[0] ^ b_sh[0];
         2'b11: begin
`ifdef ALU_SERIAL_ADD_EN
            bit_c       = a_sh[0] ^ b_sh[0] ^ carry;
            carry_nxt_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
`else
            bit_c       = 1'b0;
            carry_nxt_c = 1'b0;
`endif
         end
         default: ;
      endcase
      res_nxt_c = {bit_c, res_sh[WIDTH-1:1]};
   end

   // Datapath; S/COUT only load on the final shift so partial sums never show.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         op_q      <= 2'b00;
         res_sh    <= '0;
         cnt       <= '0;
         S         <= '0;
         COUT      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_nxt == ST_DONE);
         if (accept_c) begin
            a_sh   <= A;
            b_sh   <= B;
            op_q   <= OP;
            res_sh <= '0;
            cnt    <= '0;
         end else if (state == ST_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nxt_c;
            cnt    <= cnt + CNT_W'(1);
            if (last_c) begin
               S    <= res_nxt_c;
               COUT <= carry_nxt_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_8_bits_serial.sv
// Self-checking bench for alu_8_bits_serial: directed cases plus random operations
// against an arithmetic reference model.
module tb_alu_8_bits_serial;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic [1:0] OP;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] S;
   logic       COUT;

   int n_vec;
   int n_err;
   logic [7:0] last_s;
   logic       last_cout;

   alu_8_bits_serial #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .OP        (OP),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .COUT      (COUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {COUT, S} straight from the operation's arithmetic meaning.
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      case (op)
         2'b00: model = {1'b0, a & b};
         2'b01: model = {1'b0, a | b};
         2'b10: model = {1'b0, a ^ b};
`ifdef ALU_SERIAL_ADD_EN
         default: model = 9'({1'b0, a} + {1'b0, b});
`else
         default: model = 9'h000;
`endif
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one operation: caller is positioned #1 after an edge with the DUT idle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input int hold);
      logic [8:0] exp;
      exp = model(a, b, op);
      check("idle_ready", in_ready, 1'b1);
      A = a; B = b; OP = op; in_valid = 1'b1;
      tick();  // acceptance edge
      for (int k = 1; k <= 8; k++) begin
         // Junk on the inputs while busy must be ignored.
         in_valid  = 1'($urandom_range(0, 1));
         A         = 8'($urandom);
         B         = 8'($urandom);
         OP        = 2'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         tick();
         if (k < 8) begin
            check("shift_no_valid", out_valid, 1'b0);
            check("shift_s_stable", S, last_s);
         end
         check("busy_not_ready", in_ready, 1'b0);
      end
      check("done_valid", out_valid, 1'b1);
      check("done_s", S, exp[7:0]);
      check("done_cout", COUT, exp[8]);
      last_s    = exp[7:0];
      last_cout = exp[8];
      out_ready = 1'b0;
      in_valid  = 1'b1;
      A         = 8'h00;
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", out_valid, 1'b1);
         check("hold_s", S, last_s);
         check("hold_cout", COUT, last_cout);
         check("hold_not_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("release_valid", out_valid, 1'b0);
      check("release_ready", in_ready, 1'b1);
      check("release_s", S, last_s);
      out_ready = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      last_s = 8'h00; last_cout = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = 8'h00; B = 8'h00; OP = 2'b00;

      tick();
      tick();
      check("rst_ready_low", in_ready, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_s", S, 8'h00);
      check("rst_cout", COUT, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rst_release_ready", in_ready, 1'b1);
      tick();

      run_op(8'hFF, 8'h00, 2'b00, 0);
      run_op(8'hFF, 8'hA9, 2'b00, 1);
      run_op(8'hFF, 8'hA9, 2'b10, 0);
      run_op(8'hFF, 8'hA9, 2'b01, 2);
      run_op(8'hFF, 8'h01, 2'b11, 0);
      run_op(8'h3C, 8'h15, 2'b11, 0);
      run_op(8'hFF, 8'hFF, 2'b11, 5);
      run_op(8'h80, 8'h80, 2'b11, 5);

      // Abort with reset four cycles into an operation.
      A = 8'h5A; B = 8'hC3; OP = 2'b01; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("abort_ready_low", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      last_s = 8'h00; last_cout = 1'b0;
      check("abort_ready", in_ready, 1'b1);
      check("abort_s", S, 8'h00);
      check("abort_cout", COUT, 1'b0);
      check("abort_valid", out_valid, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("abort_no_valid", out_valid, 1'b0);
      end
      run_op(8'hFF, 8'hFF, 2'b00, 0);

      for (int i = 0; i < 30; i++)
         run_op(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_8_bits_serial.md
ALU_8_BITS_SERIAL -- requirements
Module: alu_8_bits_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; all requirements below are stated for WIDTH=8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operands and opcode presented.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 A  input  8  operand A.
REQ-007 B  input  8  operand B.
REQ-008 OP  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-009 out_valid  output  1  S/COUT hold a completed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 S  output  8  result.
REQ-012 COUT  output  1  carry out of ADD; 0 for logic ops.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE the block SHALL drive in_ready=1, out_valid=0.
REQ-015 An operation SHALL be accepted on an edge where in_valid=1 and in_ready=1: latch A, B, OP into internal shift registers, clear carry and bit counter, go to SHIFT.
REQ-016 In SHIFT the block SHALL process one bit per cycle, LSB first: result bit = OP applied to A[i], B[i] (ADD: sum of A[i], B[i], carry; carry updated); result bit shifted in at MSB of an internal result register.
REQ-017 After exactly 8 SHIFT cycles the block SHALL load S and COUT from the internal result/carry and enter DONE; out_valid SHALL rise 8 cycles after the acceptance edge.
REQ-018 S and COUT SHALL change only on entry to DONE or on reset; partial results SHALL never appear on S.
REQ-019 In SHIFT and DONE in_ready SHALL be 0; A, B, OP, in_valid changes SHALL be ignored.
REQ-020 In DONE out_valid SHALL stay 1 and S/COUT stable until an edge with out_ready=1, then go to IDLE (in_ready=1 next cycle); no back-to-back overlap.
REQ-021 ADD SHALL be modulo 256; COUT = bit 8 of A+B.
REQ-022 For AND, OR, XOR COUT SHALL be 0.
REQ-023 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-024 On an edge with rst_n=0 the FSM SHALL go to IDLE and S=0, COUT=0, out_valid=0, carry=0, counter=0; in_ready SHALL be 0 while rst_n=0.
REQ-025 Reset in SHIFT or DONE SHALL abort the operation; no result SHALL be delivered.
REQ-026 in_ready SHALL be 1 on the first cycle after rst_n returns to 1.

Configuration
REQ-027 Macro ALU_SERIAL_ADD_EN defined: OP=11 performs ADD per REQ-016/021.
REQ-028 Macro ALU_SERIAL_ADD_EN undefined: carry logic SHALL be omitted; OP=11 SHALL complete with normal timing returning S=0x00, COUT=0.

Verification
REQ-029 A=0xFF, B=0x00, OP=00 -> out_valid 8 cycles after accept, S=0x00, COUT=0.
REQ-030 A=0xFF, B=0xA9, OP=00 -> S=0xA9; then OP=10 same operands -> S=0x56; OP=01 -> S=0xFF.
REQ-031 A=0xFF, B=0x01, OP=11 (macro defined) -> S=0x00, COUT=1; A=0x3C, B=0x15 -> S=0x51, COUT=0; macro undefined -> S=0x00, COUT=0.
REQ-032 Hold out_ready=0 for 5 cycles after out_valid -> S, COUT, out_valid stable, in_ready=0; in_valid pulse with A=0x00 ignored; release -> IDLE next cycle.
REQ-033 rst_n=0 for one cycle 4 cycles after accept -> out_valid never rises, S=0x00, in_ready=1 on following cycle; new op A=B=0xFF OP=00 -> S=0xFF.
